// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
//   Shares one pipelined 8x8 multiplier among NUM_REQ requesters. A round-robin
//   arbiter picks a requester, its operands are captured and issued to the
//   multiplier, and the 16-bit product is returned tagged with the winner's
//   index.
//
//   Optional feature macro: MULT_ARB_TIMEOUT_EN
//     defined   -> WAIT aborts after TIMEOUT cycles without mult_done and
//                  answers with rsp_err=1, rsp_result=0.
//     undefined -> WAIT is unbounded and rsp_err is tied to 0.
//
// Ports
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   req             request level per requester
//   req_a, req_b    operands, slice [8*i+:8] belongs to requester i
//   gnt             one-hot pulse: requester's operands captured
//   rsp_valid       pulse: rsp_id / rsp_result / rsp_err are new
//   rsp_id          owner of the response (held until the next response)
//   rsp_result      unsigned product (held until the next response)
//   rsp_err         response is an aborted operation
//   mult_start      start pulse to the multiplier
//   mult_a, mult_b  operands to the multiplier, stable until done
//   mult_done       done from the multiplier
//   mult_result     product from the multiplier
//   busy            an operation is in progress
// -----------------------------------------------------------------------------
module mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [15:0]          rsp_result,
    output logic                 rsp_err,
    output logic                 mult_start,
    output logic [7:0]           mult_a,
    output logic [7:0]           mult_b,
    input  logic                 mult_done,
    input  logic [15:0]          mult_result,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t               state, state_nxt;
    logic [ID_W-1:0]      ptr, ptr_nxt;
    logic [ID_W-1:0]      owner, owner_nxt;
    logic [NUM_REQ-1:0]   gnt_nxt;
    logic                 rsp_valid_nxt;
    logic [ID_W-1:0]      rsp_id_nxt;
    logic [15:0]          rsp_result_nxt;
    logic                 rsp_err_nxt;
    logic                 mult_start_nxt;
    logic [7:0]           mult_a_nxt, mult_b_nxt;

    logic                 pick_vld;
    logic [ID_W-1:0]      pick_idx;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]     cnt, cnt_nxt;
`endif

    // Round-robin pick: scan downwards from the farthest offset so that the
    // requester closest to ptr (offset 0 first) is the one left standing.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NUM_REQ]) begin
                pick_vld = 1'b1;
                pick_idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt      = state;
        ptr_nxt        = ptr;
        owner_nxt      = owner;
        gnt_nxt        = '0;
        rsp_valid_nxt  = 1'b0;
        rsp_id_nxt     = rsp_id;
        rsp_result_nxt = rsp_result;
        rsp_err_nxt    = rsp_err;
        mult_start_nxt = 1'b0;
        mult_a_nxt     = mult_a;
        mult_b_nxt     = mult_b;
`ifdef MULT_ARB_TIMEOUT_EN
        cnt_nxt        = cnt;
`endif
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    gnt_nxt[pick_idx] = 1'b1;
                    mult_a_nxt        = req_a[8*pick_idx +: 8];
                    mult_b_nxt        = req_b[8*pick_idx +: 8];
                    owner_nxt         = pick_idx;
                    ptr_nxt           = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
                    state_nxt         = ISSUE;
                end
            end
            ISSUE: begin
                mult_start_nxt = 1'b1;
                state_nxt      = WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
                cnt_nxt        = '0;
`endif
            end
            WAIT: begin
                // The first WAIT cycle carries the start pulse; the multiplier
                // cannot answer then, so a done seen there is spurious.
                if (mult_done && !mult_start) begin
                    rsp_valid_nxt  = 1'b1;
                    rsp_id_nxt     = owner;
                    rsp_result_nxt = mult_result;
                    rsp_err_nxt    = 1'b0;
                    state_nxt      = RESP;
`ifdef MULT_ARB_TIMEOUT_EN
                end else if (cnt == CNT_W'(TIMEOUT)) begin
                    rsp_valid_nxt  = 1'b1;
                    rsp_id_nxt     = owner;
                    rsp_result_nxt = 16'h0000;
                    rsp_err_nxt    = 1'b1;
                    state_nxt      = RESP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
`endif
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: state and outputs update with non-blocking assignments so every
    // register samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            gnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            mult_start <= 1'b0;
            mult_a     <= '0;
            mult_b     <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            owner      <= owner_nxt;
            gnt        <= gnt_nxt;
            rsp_valid  <= rsp_valid_nxt;
            rsp_id     <= rsp_id_nxt;
            rsp_result <= rsp_result_nxt;
            mult_start <= mult_start_nxt;
            mult_a     <= mult_a_nxt;
            mult_b     <= mult_b_nxt;
            busy       <= (state_nxt != IDLE);
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            rsp_err <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            rsp_err <= rsp_err_nxt;
        end
    end
`else
    assign rsp_err = 1'b0;

    logic unused_err;
    assign unused_err = rsp_err_nxt;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_arbiter
//   Bench for mult_arbiter: a behavioural multiplier, a cycle-timeline
//   reference model with a per-cycle compare process, directed scenarios with
//   literal expectations, and a randomized request phase.
// -----------------------------------------------------------------------------
module tb_mult_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 15;

    logic                 clk   = 1'b0;
    logic                 reset = 1'b1;
    logic [NUM_REQ-1:0]   req   = '0;
    logic [8*NUM_REQ-1:0] req_a = '0;
    logic [8*NUM_REQ-1:0] req_b = '0;
    logic [NUM_REQ-1:0]   gnt;
    logic                 rsp_valid;
    logic [ID_W-1:0]      rsp_id;
    logic [15:0]          rsp_result;
    logic                 rsp_err;
    logic                 mult_start;
    logic [7:0]           mult_a, mult_b;
    logic                 mult_done   = 1'b0;
    logic [15:0]          mult_result = '0;
    logic                 busy;

    always #5 clk = ~clk;

    mult_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_err(rsp_err), .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
        .mult_done(mult_done), .mult_result(mult_result), .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural multiplier: done 4 cycles after start ----
    int mul_cd    = 0;
    bit mul_stall = 0;
    bit spur_done = 0;

    always @(posedge clk) begin
        #1;
        mult_done   = 1'b0;
        mult_result = 16'($urandom);
        if (reset) begin
            mul_cd = 0;
        end else begin
            if (mul_cd > 0) begin
                mul_cd--;
                if (mul_cd == 0 && !mul_stall) begin
                    mult_done   = 1'b1;
                    mult_result = 16'(mult_a) * 16'(mult_b);
                end
            end
            if (mult_start) mul_cd = 4;
            if (spur_done) begin
                mult_done = 1'b1;
                spur_done = 0;
            end
        end
    end

    // ---------------- reference model: timeline relative to grant cycle ----
    longint             cyc   = 0;
    bit                 m_busy = 0;
    longint             m_g   = 0;
    longint             m_r   = -1;
    int                 m_ptr = 0;
    int                 m_id  = 0;
    logic [NUM_REQ-1:0] e_gnt = '0;
    logic               e_start = 0, e_valid = 0, e_err = 0, e_busy = 0;
    logic [ID_W-1:0]    e_id = '0;
    logic [15:0]        e_result = '0;
    logic [7:0]         e_a = '0, e_b = '0;

    always @(posedge clk) begin
        bit found;
        bit done_prev;
        cyc++;
        done_prev = mult_done;
        e_gnt   = '0;
        e_start = 1'b0;
        e_valid = 1'b0;
        if (reset) begin
            m_busy = 0; m_ptr = 0; m_r = -1;
            e_a = '0; e_b = '0; e_id = '0; e_result = '0; e_err = 0; e_busy = 0;
        end else if (!m_busy) begin
            found = 0;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found && req[(m_ptr + k) % NUM_REQ]) begin
                    found = 1;
                    m_id  = (m_ptr + k) % NUM_REQ;
                end
            end
            if (found) begin
                m_busy = 1; m_g = cyc; m_r = -1;
                m_ptr  = (m_id + 1) % NUM_REQ;
                e_gnt[m_id] = 1'b1;
                e_a = req_a[8*m_id +: 8];
                e_b = req_b[8*m_id +: 8];
                e_busy = 1;
            end
        end else if (m_r >= 0 && cyc == m_r + 1) begin
            m_busy = 0;
            e_busy = 0;
        end else if (m_r < 0) begin
            if (cyc == m_g + 1) e_start = 1'b1;
            if (cyc - 1 >= m_g + 2 && done_prev) begin
                m_r = cyc; e_valid = 1; e_id = ID_W'(m_id); e_err = 0;
                e_result = 16'(e_a) * 16'(e_b);
            end
`ifdef MULT_ARB_TIMEOUT_EN
            else if (cyc == m_g + 2 + TIMEOUT) begin
                m_r = cyc; e_valid = 1; e_id = ID_W'(m_id); e_err = 1;
                e_result = 16'h0000;
            end
`endif
        end
    end

    always @(posedge clk) begin
        #2;
        check("gnt",        gnt,        e_gnt);
        check("mult_start", mult_start, e_start);
        check("mult_a",     mult_a,     e_a);
        check("mult_b",     mult_b,     e_b);
        check("busy",       busy,       e_busy);
        check("rsp_valid",  rsp_valid,  e_valid);
        check("rsp_id",     rsp_id,     e_id);
        check("rsp_result", rsp_result, e_result);
        check("rsp_err",    rsp_err,    e_err);
    end

    // ---------------- event monitor for directed literal checks -----------
    int     gnt_q[$];
    longint gcyc_q[$];
    int     rsp_q[$];
    longint start_cyc = -1;
    int     n_rsp = 0;

    always @(posedge clk) begin
        #3;
        if (!reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i]) begin
                    gnt_q.push_back(i);
                    gcyc_q.push_back(cyc);
                end
            end
            if (mult_start) start_cyc = cyc;
            if (rsp_valid) begin
                rsp_q.push_back(int'(rsp_id));
                n_rsp++;
            end
        end
    end

    // ---------------- stimulus helpers ------------------------------------
    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        req   = '0;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                          output longint gc, output longint rc);
        @(negedge clk);
        req = '0;
        req[idx] = 1'b1;
        req_a[8*idx +: 8] = a;
        req_b[8*idx +: 8] = b;
        gc = -1;
        rc = -1;
        for (int n = 0; n < 20 && gc < 0; n++) begin
            @(posedge clk); #3;
            if (gnt != '0) gc = cyc;
        end
        check("gnt_seen", gc >= 0, 1);
        @(negedge clk);
        req = '0;
        for (int n = 0; n < 40 && rc < 0; n++) begin
            @(posedge clk); #3;
            if (rsp_valid) rc = cyc;
        end
        check("rsp_seen", rc >= 0, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 60) begin
            @(posedge clk); #3;
            n++;
        end
        check("idle_reached", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ---------------------------------------
    initial begin
        longint gc, rc;
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #3;
        check("reset_gnt",  gnt,        0);
        check("reset_busy", busy,       0);
        check("reset_res",  rsp_result, 0);

        // Single operation, latency pinned by literals.
        run_op(0, 8'd12, 8'd13, gc, rc);
        check("t1_start_lat", 32'(start_cyc - gc), 1);
        check("t1_rsp_lat",   32'(rc - gc),        6);
        check("t1_id",        rsp_id,              0);
        check("t1_result",    rsp_result,          16'd156);
        check("t1_err",       rsp_err,             0);
        repeat (2) @(posedge clk);

        // Extremes on requester 3.
        run_op(3, 8'hFF, 8'hFF, gc, rc);
        check("t2_id",    rsp_id,     3);
        check("t2_ff_ff", rsp_result, 16'hFE01);
        run_op(3, 8'h00, 8'hFF, gc, rc);
        check("t2_00_ff", rsp_result, 16'h0000);
        wait_idle();

        // Fairness with all requesters held high from ptr=0.
        do_reset(2);
        gnt_q.delete(); gcyc_q.delete(); rsp_q.delete();
        @(negedge clk);
        req = '1;
        req_a = 32'($urandom);
        req_b = 32'($urandom);
        for (int n = 0; n < 80 && gnt_q.size() < 5; n++) @(posedge clk);
        @(negedge clk);
        req = '0;
        for (int n = 0; n < 40 && rsp_q.size() < 5; n++) @(posedge clk);
        check("t3_gnt_count", gnt_q.size(), 5);
        check("t3_rsp_count", rsp_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < gnt_q.size()) check("t3_gnt_order", gnt_q[i], exp_order[i]);
            if (i < rsp_q.size()) check("t3_rsp_order", rsp_q[i], exp_order[i]);
            if (i > 0 && i < gcyc_q.size())
                check("t3_gnt_gap", (gcyc_q[i] - gcyc_q[i-1]) >= 7, 1);
        end
        wait_idle();

        // Reset in the middle of an operation.
        @(negedge clk);
        req[2] = 1'b1;
        req_a[23:16] = 8'd5;
        req_b[23:16] = 8'd7;
        gc = -1;
        for (int n = 0; n < 20 && gc < 0; n++) begin
            @(posedge clk); #3;
            if (gnt != '0) gc = cyc;
        end
        check("t4_gnt_seen", gc >= 0, 1);
        @(negedge clk);
        req = '0;
        @(negedge clk);
        begin
            int rsp_before;
            rsp_before = n_rsp;
            do_reset(2);
            repeat (10) @(posedge clk);
            #3;
            check("t4_no_rsp", n_rsp - rsp_before, 0);
            check("t4_busy",   busy,   0);
            check("t4_mult_a", mult_a, 0);
        end
        run_op(1, 8'd200, 8'd3, gc, rc);
        check("t4_after_result", rsp_result, 16'd600);
        check("t4_after_id",     rsp_id,     1);
        wait_idle();

        // Spurious done while idle.
        begin
            int rsp_before;
            rsp_before = n_rsp;
            @(negedge clk);
            spur_done = 1;
            repeat (4) begin
                @(posedge clk); #3;
                check("t5_busy", busy, 0);
            end
            check("t5_no_rsp", n_rsp - rsp_before, 0);
        end

`ifdef MULT_ARB_TIMEOUT_EN
        // Multiplier never answers: abort after TIMEOUT cycles.
        mul_stall = 1;
        run_op(1, 8'd7, 8'd9, gc, rc);
        check("t6_rsp_lat", 32'(rc - gc), 2 + TIMEOUT);
        check("t6_err",     rsp_err,      1);
        check("t6_result",  rsp_result,   0);
        mul_stall = 0;
        wait_idle();
        run_op(2, 8'd7, 8'd9, gc, rc);
        check("t6_next_result", rsp_result, 16'd63);
        check("t6_next_err",    rsp_err,    0);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            req = NUM_REQ'($urandom) & NUM_REQ'($urandom);
            for (int i = 0; i < NUM_REQ; i++) begin
                case ($urandom_range(0, 7))
                    0:       req_a[8*i +: 8] = 8'hFF;
                    1:       req_a[8*i +: 8] = 8'h00;
                    default: req_a[8*i +: 8] = 8'($urandom);
                endcase
                case ($urandom_range(0, 7))
                    0:       req_b[8*i +: 8] = 8'hFF;
                    1:       req_b[8*i +: 8] = 8'h00;
                    default: req_b[8*i +: 8] = 8'($urandom);
                endcase
            end
        end
        @(negedge clk);
        req = '0;
        repeat (2) @(posedge clk);
        #3;
        wait_idle();
        repeat (3) @(posedge clk);
        #4;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
